// File: rtl/lnrv_exu_alu_arbt_pkg.sv
// Shared types and constants for the EXU ALU arbiter.
// Optional macro LNRV_ALU_ARBT_RR_EN selects round-robin instead of fixed priority.
package lnrv_exu_alu_arbt_pkg;

    localparam int ALU_OP_BUS_WIDTH = 16;

    typedef enum logic [1:0] {
        ALU_ARBT_IDLE  = 2'd0,
        ALU_ARBT_ISSUE = 2'd1,
        ALU_ARBT_WAIT  = 2'd2
    } alu_arbt_state_e;

    localparam logic [1:0] ALU_REQ_RGLR = 2'd0;
    localparam logic [1:0] ALU_REQ_BRCH = 2'd1;
    localparam logic [1:0] ALU_REQ_CSR  = 2'd2;
    localparam logic [1:0] ALU_REQ_LSU  = 2'd3;

endpackage

// File: rtl/lnrv_exu_alu_arbt_pick.sv
// Combinational 4-way picker: one-hot grant plus index.
// LNRV_ALU_ARBT_RR_EN: scan from ptr+1; otherwise fixed priority 0 > 1 > 2 > 3.
module lnrv_exu_alu_arbt_pick
    import lnrv_exu_alu_arbt_pkg::*;
(
    input  logic [3:0] req_vld,
    input  logic [1:0] ptr,
    output logic [3:0] gnt,
    output logic [1:0] idx
);

    logic       found;
    logic [1:0] cand;

`ifdef LNRV_ALU_ARBT_RR_EN
    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        cand  = '0;
        for (int k = 1; k <= 4; k++) begin
            cand = ptr + 2'(k);
            if (!found && req_vld[cand]) begin
                gnt[cand] = 1'b1;
                idx       = cand;
                found     = 1'b1;
            end
        end
    end
`else
    logic unused_ptr;
    assign unused_ptr = ^ptr;

    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        cand  = '0;
        for (int k = 0; k < 4; k++) begin
            cand = 2'(k);
            if (!found && req_vld[cand]) begin
                gnt[cand] = 1'b1;
                idx       = cand;
                found     = 1'b1;
            end
        end
    end
`endif

endmodule

// File: rtl/lnrv_exu_alu_arbt.sv
// Lockable handshaked arbiter sharing the EXU ALU between rglr/brch/csr/lsu.
// LNRV_ALU_ARBT_RR_EN enables round-robin arbitration (default: fixed priority).
module lnrv_exu_alu_arbt
    import lnrv_exu_alu_arbt_pkg::*;
#(
    parameter int OPW  = ALU_OP_BUS_WIDTH,
    parameter int DW   = 32,
    parameter int NREQ = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush,
    input  logic [NREQ-1:0]      req_vld,
    output logic [NREQ-1:0]      req_rdy,
    input  logic [NREQ*OPW-1:0]  req_op_bus,
    input  logic [NREQ*DW-1:0]   req_in1,
    input  logic [NREQ*DW-1:0]   req_in2,
    output logic [NREQ-1:0]      rsp_vld,
    input  logic [NREQ-1:0]      rsp_rdy,
    output logic [DW-1:0]        rsp_res,
    output logic                 alu_op_vld,
    input  logic                 alu_op_rdy,
    output logic [OPW-1:0]       alu_op_bus,
    output logic [DW-1:0]        alu_in1,
    output logic [DW-1:0]        alu_in2,
    input  logic                 alu_rsp_vld,
    output logic                 alu_rsp_rdy,
    input  logic [DW-1:0]        alu_rsp_res,
    output logic                 busy
);

    alu_arbt_state_e state_q, state_d;
    logic [1:0]      gnt_idx_q, gnt_idx_d;
    logic            flushed_q, flushed_d;
    logic [OPW-1:0]  op_q, op_d;
    logic [DW-1:0]   in1_q, in1_d;
    logic [DW-1:0]   in2_q, in2_d;
    logic            grant;
    logic            rsp_ack;
    logic [1:0]      ptr;
    logic [3:0]      pick_gnt;
    logic [1:0]      pick_idx;

    lnrv_exu_alu_arbt_pick u_pick (
        .req_vld (req_vld),
        .ptr     (ptr),
        .gnt     (pick_gnt),
        .idx     (pick_idx)
    );

`ifdef LNRV_ALU_ARBT_RR_EN
    logic [1:0] rr_ptr_q, rr_ptr_d;

    assign rr_ptr_d = grant ? pick_idx : rr_ptr_q;
    assign ptr      = rr_ptr_q;

    // Reset to 3 so requester 0 is scanned first.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rr_ptr_q <= 2'd3;
        else        rr_ptr_q <= rr_ptr_d;
    end
`else
    assign ptr = 2'd3;
`endif

    always_comb begin
        state_d     = state_q;
        gnt_idx_d   = gnt_idx_q;
        flushed_d   = flushed_q;
        op_d        = op_q;
        in1_d       = in1_q;
        in2_d       = in2_q;
        grant       = 1'b0;
        rsp_ack     = 1'b0;
        req_rdy     = '0;
        rsp_vld     = '0;
        alu_rsp_rdy = 1'b0;
        case (state_q)
            ALU_ARBT_IDLE: begin
                // rst_n gate keeps req_rdy low while reset is held.
                if (rst_n && !flush && (|req_vld)) begin
                    grant     = 1'b1;
                    req_rdy   = pick_gnt;
                    gnt_idx_d = pick_idx;
                    flushed_d = 1'b0;
                    op_d      = req_op_bus[pick_idx*OPW +: OPW];
                    in1_d     = req_in1[pick_idx*DW +: DW];
                    in2_d     = req_in2[pick_idx*DW +: DW];
                    state_d   = ALU_ARBT_ISSUE;
                end
            end
            ALU_ARBT_ISSUE: begin
                if (flush)      flushed_d = 1'b1;
                if (alu_op_rdy) state_d   = ALU_ARBT_WAIT;
            end
            ALU_ARBT_WAIT: begin
                if (flush) flushed_d = 1'b1;
                rsp_ack     = flushed_q | flush | rsp_rdy[gnt_idx_q];
                alu_rsp_rdy = rsp_ack;
                if (alu_rsp_vld && !flushed_q && !flush) rsp_vld[gnt_idx_q] = 1'b1;
                if (alu_rsp_vld && rsp_ack) state_d = ALU_ARBT_IDLE;
            end
            default: state_d = ALU_ARBT_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ALU_ARBT_IDLE;
            gnt_idx_q <= '0;
            flushed_q <= 1'b0;
            op_q      <= '0;
            in1_q     <= '0;
            in2_q     <= '0;
        end else begin
            state_q   <= state_d;
            gnt_idx_q <= gnt_idx_d;
            flushed_q <= flushed_d;
            op_q      <= op_d;
            in1_q     <= in1_d;
            in2_q     <= in2_d;
        end
    end

    assign alu_op_vld = (state_q == ALU_ARBT_ISSUE);
    assign alu_op_bus = op_q;
    assign alu_in1    = in1_q;
    assign alu_in2    = in2_q;
    assign rsp_res    = alu_rsp_res;
    assign busy       = (state_q != ALU_ARBT_IDLE);

endmodule

// File: doc/lnrv_exu_alu_arbt.md
Name: lnrv_exu_alu_arbt

Overview:
- Sequencing arbiter that shares the single EXU ALU between four requesters: 0=rglr, 1=brch, 2=csr, 3=lsu.
- Grants one requester and registers its operation into an ALU issue stage.
- Holds the grant until the ALU result has been returned to that requester, so at most one operation is in flight.
- Sits between the EXU functional units and lnrv_exu_alu; replaces OR-based muxing with a true handshaked, lockable grant.

Parameters:
- OPW, `ALU_OP_BUS_WIDTH, ALU op bus width.
- DW, 32, operand/result width.
- NREQ, 4, requester count; fixed at 4, and the pointer logic assumes 4.

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  pipeline flush; kills pending and in-flight results
- req_vld  in  4  per-requester op valid
- req_rdy  out  4  per-requester op accept (one-hot or zero)
- req_op_bus  in  4*OPW  packed op buses, requester i at [i*OPW +: OPW]
- req_in1  in  4*DW  packed operand 1
- req_in2  in  4*DW  packed operand 2
- rsp_vld  out  4  per-requester result valid (one-hot or zero)
- rsp_rdy  in  4  per-requester result accept
- rsp_res  out  DW  result, shared by all requesters
- alu_op_vld  out  1  issue valid to ALU
- alu_op_rdy  in  1  ALU accepts issue
- alu_op_bus  out  OPW  registered op
- alu_in1  out  DW  registered operand 1
- alu_in2  out  DW  registered operand 2
- alu_rsp_vld  in  1  ALU result valid
- alu_rsp_rdy  out  1  result accept toward ALU
- alu_rsp_res  in  DW  ALU result
- busy  out  1  state != IDLE

Behaviour:
- Clock and reset: single clock clk; reset rst_n is asynchronous, active-low.
- Reset values: state=IDLE, gnt_idx=0, rr_ptr=3, flushed=0, alu_op_vld=0, alu_op_bus=0, alu_in1=0, alu_in2=0.
- Combinational outputs during reset: req_rdy=0, rsp_vld=0, alu_rsp_rdy=0, busy=0.
- FSM states are IDLE, ISSUE and WAIT.
- IDLE:
  - If flush=0 and any req_vld, select winner w and drive req_rdy=onehot(w) in the same cycle; req_rdy is never driven without the matching req_vld.
  - On the handshake, register op/in1/in2 of w, set gnt_idx=w, update rr_ptr=w, clear flushed, and go to ISSUE.
  - If flush=1, req_rdy=0 and the FSM stays in IDLE.
- ISSUE:
  - alu_op_vld=1; op_bus/in1/in2 stay stable until alu_op_rdy.
  - On alu_op_rdy, go to WAIT.
  - alu_op_vld must not drop without the handshake; a flush here only sets flushed=1.
- WAIT:
  - alu_rsp_rdy = flushed | flush | rsp_rdy[gnt_idx].
  - rsp_vld[gnt_idx] = alu_rsp_vld & ~flushed & ~flush, and rsp_res = alu_rsp_res.
  - On alu_rsp_vld & alu_rsp_rdy, go to IDLE.
  - A flush in WAIT sets flushed; the result is later consumed and dropped.
- Response timing:
  - alu_rsp_rdy=0 and rsp_vld=0 outside WAIT.
  - The ALU must not present a result before its op handshake.
- Latency:
  - Request accepted in cycle N gives alu_op_vld in N+1.
  - With a 1-cycle ALU and ready consumers, the result is seen in N+2 and a new grant can be made in N+3.
- Throughput: one op per 3 cycles minimum.
- Simultaneous events:
  - Multiple req_vld: one winner only; the losers see req_rdy=0 and must hold their request.
  - flush and req_vld in IDLE: no grant.
  - flush and the alu_rsp handshake in WAIT: the result is dropped and the FSM returns to IDLE.
  - Reset mid-operation: asynchronous return to IDLE; any ALU result still outstanding is the ALU's responsibility to clear on the same reset.

Optional Feature:
- Macro: LNRV_ALU_ARBT_RR_EN.
- Defined (round-robin):
  - The winner is the first requester with req_vld, scanning from (rr_ptr+1) mod 4 upward.
  - rr_ptr updates on each grant and resets to 3, so requester 0 has first priority after reset.
- Undefined (fixed priority):
  - Priority order is 0 > 1 > 2 > 3.
  - The rr_ptr register and its update logic are not generated.

Decomposition:
- Shared package/defines (lnrv_def.v) holds:
  - `ALU_ARBT_IDLE/ISSUE/WAIT state encodings (2 bits);
  - requester index constants `ALU_REQ_RGLR=0, BRCH=1, CSR=2, LSU=3.
- One sub-module: lnrv_exu_alu_arbt_pick, a combinational 4-way picker with inputs req_vld[3:0] and ptr[1:0], and outputs a one-hot grant plus an index.
  - The RR/fixed choice is made inside the picker.

Test Plan:
- Single request: req_vld=4'b0100 with op=ADD, in1=5, in2=7 → req_rdy=4'b0100 in the same cycle, then alu_op_vld next cycle. The ALU returns 12 → rsp_vld=4'b0100 with rsp_res=12, busy falls after the response handshake.
- All four requesting continuously (RR_EN defined) → grant order 0,1,2,3,0. Without RR_EN → 0 every time.
- alu_op_rdy held low for 5 cycles → alu_op_vld and alu_op_bus/alu_in1/alu_in2 are stable across all 5 cycles, and req_rdy=0 throughout.
- rsp_rdy[gnt] low for 3 cycles while alu_rsp_vld=1 → alu_rsp_rdy=0 and rsp_vld is held; the FSM leaves WAIT only on the cycle rsp_rdy rises.
- flush pulse in ISSUE → the op still issues; in WAIT the result is consumed with rsp_vld=4'b0000, then the FSM returns to IDLE and the next request is granted.
- rst_n asserted in WAIT → alu_op_vld=0 and busy=0 immediately (asynchronous). After release, the first grant goes to requester 0.
